execute_stage: RTL and testbench

//  C (execute) stage of the 5-stage RV32I pipeline: B/C pipeline register, operand forwarding

---
 rtl/execute_stage.sv | 144 ++++++++++++++
 tb/tb_execute_stage.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - RV32I execute stage: B/C register, forwarding, ALU, branch resolve, C/D register
module execute_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  StallC,
    input  logic                  FlushC,
    input  logic [DATA_WIDTH-1:0] RD1B,
    input  logic [DATA_WIDTH-1:0] RD2B,
    input  logic [DATA_WIDTH-1:0] ImmExtB,
    input  logic [DATA_WIDTH-1:0] PCB,
    input  logic [DATA_WIDTH-1:0] PCPlus4B,
    input  logic [4:0]            Rs1B,
    input  logic [4:0]            Rs2B,
    input  logic [4:0]            RdB,
    input  logic [3:0]            ALUControlB,
    input  logic                  ALUSrcB,
    input  logic [2:0]            Funct3B,
    input  logic                  BranchB,
    input  logic                  JumpB,
    input  logic                  JalrB,
    input  logic                  RegWriteB,
    input  logic                  MemWriteB,
    input  logic [1:0]            ResultSrcB,
    input  logic [1:0]            ForwardAH,
    input  logic [1:0]            ForwardBH,
    input  logic [DATA_WIDTH-1:0] WriteResultEH,
    output logic [4:0]            Rs1CH,
    output logic [4:0]            Rs2CH,
    output logic                  PCSrcC,
    output logic [DATA_WIDTH-1:0] PCTargetC,
    output logic [DATA_WIDTH-1:0] ALUResultD,
    output logic [DATA_WIDTH-1:0] WriteDataD,
    output logic [DATA_WIDTH-1:0] PCPlus4D,
    output logic [4:0]            RdD,
    output logic                  RegWriteD,
    output logic                  MemWriteD,
    output logic [1:0]            ResultSrcD
);
    localparam int DW = DATA_WIDTH;

    logic [DW-1:0] r_rd1_c, r_rd2_c, r_imm_c, r_pc_c, r_pc4_c;
    logic [4:0]    r_rs1_c, r_rs2_c, r_rd_c;
    logic [3:0]    r_aluctl_c;
    logic [2:0]    r_funct3_c;
    logic [1:0]    r_ressrc_c;
    logic          r_alusrc_c, r_branch_c, r_jump_c, r_jalr_c, r_regwr_c, r_memwr_c;

    logic [DW-1:0] w_src_a, w_fwd_b, w_src_b, w_alu, w_jalr_sum;
    logic [4:0]    w_shamt;
    logic          w_cond;

    // A flushed C register is an all-zero bubble: no write, no branch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || FlushC) begin
            if (!rst_n || FlushC) begin
                r_rd1_c <= '0; r_rd2_c <= '0; r_imm_c <= '0; r_pc_c <= '0; r_pc4_c <= '0;
                r_rs1_c <= '0; r_rs2_c <= '0; r_rd_c <= '0;
                r_aluctl_c <= '0; r_funct3_c <= '0; r_ressrc_c <= '0;
                r_alusrc_c <= 1'b0; r_branch_c <= 1'b0; r_jump_c <= 1'b0;
                r_jalr_c <= 1'b0; r_regwr_c <= 1'b0; r_memwr_c <= 1'b0;
            end
        end else if (!StallC) begin
            r_rd1_c <= RD1B; r_rd2_c <= RD2B; r_imm_c <= ImmExtB; r_pc_c <= PCB; r_pc4_c <= PCPlus4B;
            r_rs1_c <= Rs1B; r_rs2_c <= Rs2B; r_rd_c <= RdB;
            r_aluctl_c <= ALUControlB; r_funct3_c <= Funct3B; r_ressrc_c <= ResultSrcB;
            r_alusrc_c <= ALUSrcB; r_branch_c <= BranchB; r_jump_c <= JumpB;
            r_jalr_c <= JalrB; r_regwr_c <= RegWriteB; r_memwr_c <= MemWriteB;
        end
    end

    always_comb begin
        case (ForwardAH)
            2'b01:   w_src_a = WriteResultEH;
            2'b10:   w_src_a = ALUResultD;
            default: w_src_a = r_rd1_c;
        endcase
        case (ForwardBH)
            2'b01:   w_fwd_b = WriteResultEH;
            2'b10:   w_fwd_b = ALUResultD;
            default: w_fwd_b = r_rd2_c;
        endcase
    end

    assign w_src_b = r_alusrc_c ? r_imm_c : w_fwd_b;
    assign w_shamt = w_src_b[4:0];

    always_comb begin
        w_alu = '0;
        case (r_aluctl_c)
            4'b0000: w_alu = w_src_a + w_src_b;
            4'b0001: w_alu = w_src_a - w_src_b;
            4'b0010: w_alu = w_src_a & w_src_b;
            4'b0011: w_alu = w_src_a | w_src_b;
            4'b0100: w_alu = w_src_a ^ w_src_b;
            4'b0101: w_alu = {{(DW-1){1'b0}}, ($signed(w_src_a) < $signed(w_src_b))};
            4'b0110: w_alu = {{(DW-1){1'b0}}, (w_src_a < w_src_b)};
            4'b0111: w_alu = w_src_a << w_shamt;
            4'b1000: w_alu = w_src_a >> w_shamt;
            4'b1001: w_alu = $unsigned($signed(w_src_a) >>> w_shamt);
            4'b1010: w_alu = w_src_b;
            default: w_alu = '0;
        endcase
    end

    // Branch compare always uses the register operand, never the immediate.
    always_comb begin
        w_cond = 1'b0;
        case (r_funct3_c)
            3'b000:  w_cond = (w_src_a == w_fwd_b);
            3'b001:  w_cond = (w_src_a != w_fwd_b);
            3'b100:  w_cond = ($signed(w_src_a) < $signed(w_fwd_b));
            3'b101:  w_cond = ($signed(w_src_a) >= $signed(w_fwd_b));
            3'b110:  w_cond = (w_src_a < w_fwd_b);
            3'b111:  w_cond = (w_src_a >= w_fwd_b);
            default: w_cond = 1'b0;
        endcase
    end

    assign w_jalr_sum = w_src_a + r_imm_c;
    assign PCSrcC     = r_jump_c | (r_branch_c & w_cond);
    assign PCTargetC  = r_jalr_c ? {w_jalr_sum[DW-1:1], 1'b0} : (r_pc_c + r_imm_c);
    assign Rs1CH      = r_rs1_c;
    assign Rs2CH      = r_rs2_c;

    // A stall freezes C, so D must take a bubble rather than a duplicate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || StallC) begin
            if (!rst_n || StallC) begin
                ALUResultD <= '0; WriteDataD <= '0; PCPlus4D <= '0;
                RdD <= '0; RegWriteD <= 1'b0; MemWriteD <= 1'b0; ResultSrcD <= '0;
            end
        end else begin
            ALUResultD <= w_alu;
            WriteDataD <= w_fwd_b;
            PCPlus4D   <= r_pc4_c;
            RdD        <= r_rd_c;
            RegWriteD  <= r_regwr_c;
            MemWriteD  <= r_memwr_c;
            ResultSrcD <= r_ressrc_c;
        end
    end
endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - self-checking bench for execute_stage against a behavioural pipeline model
module tb_execute_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        StallC = 1'b0, FlushC = 1'b0;
    logic [31:0] RD1B, RD2B, ImmExtB, PCB, PCPlus4B, WriteResultEH;
    logic [4:0]  Rs1B, Rs2B, RdB;
    logic [3:0]  ALUControlB;
    logic        ALUSrcB, BranchB, JumpB, JalrB, RegWriteB, MemWriteB;
    logic [2:0]  Funct3B;
    logic [1:0]  ResultSrcB, ForwardAH, ForwardBH;
    logic [4:0]  Rs1CH, Rs2CH, RdD;
    logic        PCSrcC, RegWriteD, MemWriteD;
    logic [31:0] PCTargetC, ALUResultD, WriteDataD, PCPlus4D;
    logic [1:0]  ResultSrcD;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] rd1, rd2, imm, pc, pc4;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  op;
        logic        alusrc;
        logic [2:0]  f3;
        logic        br, jmp, jalr, rw, mw;
        logic [1:0]  rs;
    } c_t;

    typedef struct packed {
        logic [31:0] alu, wd, pc4;
        logic [4:0]  rd;
        logic        rw, mw;
        logic [1:0]  rs;
    } d_t;

    c_t mC = '0;
    d_t mD = '0;

    execute_stage #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .StallC(StallC), .FlushC(FlushC),
        .RD1B(RD1B), .RD2B(RD2B), .ImmExtB(ImmExtB), .PCB(PCB), .PCPlus4B(PCPlus4B),
        .Rs1B(Rs1B), .Rs2B(Rs2B), .RdB(RdB), .ALUControlB(ALUControlB), .ALUSrcB(ALUSrcB),
        .Funct3B(Funct3B), .BranchB(BranchB), .JumpB(JumpB), .JalrB(JalrB),
        .RegWriteB(RegWriteB), .MemWriteB(MemWriteB), .ResultSrcB(ResultSrcB),
        .ForwardAH(ForwardAH), .ForwardBH(ForwardBH), .WriteResultEH(WriteResultEH),
        .Rs1CH(Rs1CH), .Rs2CH(Rs2CH), .PCSrcC(PCSrcC), .PCTargetC(PCTargetC),
        .ALUResultD(ALUResultD), .WriteDataD(WriteDataD), .PCPlus4D(PCPlus4D),
        .RdD(RdD), .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .ResultSrcD(ResultSrcD)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_fwd(input logic [1:0] sel, input logic [31:0] regv);
        if (sel == 2'd1) return WriteResultEH;
        if (sel == 2'd2) return mD.alu;
        return regv;
    endfunction

    function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (op)
            4'd0:  return a + b;
            4'd1:  return a + ~b + 32'd1;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd6:  return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
            4'd7:  return 32'(longint'(a) * (longint'(1) << sh));
            4'd8:  return 32'(longint'(a) / (longint'(1) << sh));
            4'd9:  return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
            4'd10: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return int'(a) < int'(b);
            3'd5: return !(int'(a) < int'(b));
            3'd6: return longint'(a) < longint'(b);
            3'd7: return !(longint'(a) < longint'(b));
            default: return 1'b0;
        endcase
    endfunction

    function automatic d_t m_exec(input c_t c);
        d_t d;
        logic [31:0] a, fb;
        a = m_fwd(ForwardAH, c.rd1);
        fb = m_fwd(ForwardBH, c.rd2);
        d.alu = m_alu(c.op, a, c.alusrc ? c.imm : fb);
        d.wd = fb; d.pc4 = c.pc4; d.rd = c.rd; d.rw = c.rw; d.mw = c.mw; d.rs = c.rs;
        return d;
    endfunction

    function automatic logic [32:0] m_redirect(input c_t c);
        logic [31:0] a, fb, t;
        a = m_fwd(ForwardAH, c.rd1);
        fb = m_fwd(ForwardBH, c.rd2);
        t = c.jalr ? ((a + c.imm) & 32'hFFFF_FFFE) : (c.pc + c.imm);
        return {c.jmp | (c.br & m_taken(c.f3, a, fb)), t};
    endfunction

    function automatic c_t b_now();
        return '{RD1B, RD2B, ImmExtB, PCB, PCPlus4B, Rs1B, Rs2B, RdB, ALUControlB, ALUSrcB,
                 Funct3B, BranchB, JumpB, JalrB, RegWriteB, MemWriteB, ResultSrcB};
    endfunction

    task automatic clear_b();
        RD1B = 0; RD2B = 0; ImmExtB = 0; PCB = 0; PCPlus4B = 0; Rs1B = 0; Rs2B = 0; RdB = 0;
        ALUControlB = 0; ALUSrcB = 0; Funct3B = 0; BranchB = 0; JumpB = 0; JalrB = 0;
        RegWriteB = 0; MemWriteB = 0; ResultSrcB = 0;
    endtask

    task automatic rand_b();
        RD1B = $urandom; RD2B = ($urandom % 4 == 0) ? RD1B : $urandom;
        ImmExtB = ($urandom % 2) ? $urandom : 32'($urandom_range(0, 40));
        PCB = $urandom & 32'hFFFF_FFFC; PCPlus4B = PCB + 4;
        Rs1B = 5'($urandom); Rs2B = 5'($urandom); RdB = 5'($urandom);
        ALUControlB = 4'($urandom); ALUSrcB = 1'($urandom); Funct3B = 3'($urandom);
        BranchB = 1'($urandom); JumpB = ($urandom % 4 == 0); JalrB = 1'($urandom);
        RegWriteB = 1'($urandom); MemWriteB = 1'($urandom); ResultSrcB = 2'($urandom);
    endtask

    // One rising edge with the model advanced by the same rules.
    task automatic step();
        c_t nc;
        d_t nd;
        if (!rst_n) begin
            nc = '0; nd = '0;
        end else begin
            nd = StallC ? d_t'(0) : m_exec(mC);
            nc = FlushC ? c_t'(0) : (StallC ? mC : b_now());
        end
        @(posedge clk);
        mC = nc; mD = nd;
        #1;
    endtask

    task automatic test_reset();
        rand_b(); ForwardAH = 0; ForwardBH = 0; WriteResultEH = $urandom;
        rst_n = 1'b0;
        step(); step();
        checks++;
        if ({ALUResultD, WriteDataD, PCPlus4D, RdD, RegWriteD, MemWriteD, ResultSrcD} !== 105'd0) begin
            errors++; $display("FAIL reset_d: got %h want 0", {ALUResultD, WriteDataD, PCPlus4D, RdD, RegWriteD, MemWriteD, ResultSrcD});
        end
        checks++;
        if ({Rs1CH, Rs2CH, PCSrcC, PCTargetC} !== 43'd0) begin
            errors++; $display("FAIL reset_c: got %h want 0", {Rs1CH, Rs2CH, PCSrcC, PCTargetC});
        end
        rst_n = 1'b1;
        clear_b();
    endtask

    task automatic test_add();
        clear_b(); RD1B = 5; RD2B = 7; Rs1B = 1; Rs2B = 2; RdB = 3; RegWriteB = 1;
        step();
        clear_b();
        step();
        checks++;
        if ({ALUResultD, RdD, RegWriteD} !== {32'd12, 5'd3, 1'b1}) begin
            errors++; $display("FAIL add: got alu=%h rd=%0d rw=%b want 12/3/1", ALUResultD, RdD, RegWriteD);
        end
    endtask

    task automatic test_forward();
        clear_b(); RD1B = 32'h100; ALUSrcB = 1; RdB = 1; RegWriteB = 1;
        step();
        clear_b(); RD1B = 1; ImmExtB = 4; ALUSrcB = 1; RdB = 2; RegWriteB = 1;
        step();
        ForwardAH = 2'b10;
        clear_b(); RD1B = 32'h10; RD2B = 32'h55; ImmExtB = 8; ALUSrcB = 1; MemWriteB = 1;
        step();
        checks++;
        if (ALUResultD !== 32'h104) begin
            errors++; $display("FAIL fwd_a: got %h want 00000104", ALUResultD);
        end
        ForwardAH = 2'b00; ForwardBH = 2'b01; WriteResultEH = 9;
        clear_b();
        step();
        checks++;
        if ({WriteDataD, MemWriteD, ALUResultD} !== {32'd9, 1'b1, 32'h18}) begin
            errors++; $display("FAIL fwd_b_sw: got wd=%h mw=%b alu=%h want 9/1/18", WriteDataD, MemWriteD, ALUResultD);
        end
        ForwardBH = 2'b00;
    endtask

    task automatic test_branch();
        clear_b(); RD1B = 32'h20; RD2B = 32'h20; PCB = 32'h40; ImmExtB = 32'hFFFF_FFF8;
        BranchB = 1; Funct3B = 3'b000; ALUControlB = 4'd1;
        step();
        checks++;
        if ({PCSrcC, PCTargetC} !== {1'b1, 32'h38}) begin
            errors++; $display("FAIL beq: got src=%b tgt=%h want 1/00000038", PCSrcC, PCTargetC);
        end
        Funct3B = 3'b001;
        step();
        checks++;
        if (PCSrcC !== 1'b0) begin
            errors++; $display("FAIL bne: got %b want 0", PCSrcC);
        end
        Funct3B = 3'b011;
        step();
        checks++;
        if (PCSrcC !== 1'b0) begin
            errors++; $display("FAIL f3_011: got %b want 0", PCSrcC);
        end
        clear_b();
    endtask

    task automatic test_jalr();
        clear_b(); RD1B = 32'h1003; JumpB = 1; JalrB = 1; ALUSrcB = 1; PCB = 32'h200;
        PCPlus4B = 32'h204; RdB = 1; RegWriteB = 1;
        step();
        checks++;
        if ({PCSrcC, PCTargetC} !== {1'b1, 32'h1002}) begin
            errors++; $display("FAIL jalr: got src=%b tgt=%h want 1/00001002", PCSrcC, PCTargetC);
        end
        clear_b();
        step();
        checks++;
        if (PCPlus4D !== 32'h204) begin
            errors++; $display("FAIL jalr_link: got %h want 00000204", PCPlus4D);
        end
    endtask

    task automatic test_stall_flush();
        clear_b(); RD1B = 3; Rs1B = 7; Rs2B = 8; RdB = 5; RegWriteB = 1;
        step();
        StallC = 1; Rs1B = 9; Rs2B = 10; RdB = 6;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({Rs1CH, Rs2CH, RegWriteD} !== {5'd7, 5'd8, 1'b0}) begin
                errors++; $display("FAIL stall_%0d: got rs1=%0d rs2=%0d rw=%b want 7/8/0", i, Rs1CH, Rs2CH, RegWriteD);
            end
        end
        FlushC = 1;
        step();
        checks++;
        if ({Rs1CH, Rs2CH, PCSrcC, RegWriteD} !== 12'd0) begin
            errors++; $display("FAIL flush_stall: got rs1=%0d rs2=%0d src=%b rw=%b want 0", Rs1CH, Rs2CH, PCSrcC, RegWriteD);
        end
        FlushC = 0; StallC = 0;
        clear_b();
        step();
        checks++;
        if ({RdD, RegWriteD} !== 6'd0) begin
            errors++; $display("FAIL flush_bubble: got rd=%0d rw=%b want 0", RdD, RegWriteD);
        end
    endtask

    task automatic test_shift_compare();
        clear_b(); RD1B = 32'h8000_0000; ImmExtB = 31; ALUSrcB = 1; ALUControlB = 4'd9;
        step();
        clear_b(); RD1B = 1; RD2B = 32'hFFFF_FFFF; ALUControlB = 4'd6;
        step();
        checks++;
        if (ALUResultD !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL sra: got %h want ffffffff", ALUResultD);
        end
        ALUControlB = 4'd5;
        step();
        checks++;
        if (ALUResultD !== 32'd1) begin
            errors++; $display("FAIL sltu: got %h want 1", ALUResultD);
        end
        clear_b();
        step();
        checks++;
        if (ALUResultD !== 32'd0) begin
            errors++; $display("FAIL slt: got %h want 0", ALUResultD);
        end
    endtask

    task automatic test_random();
        logic [32:0] r;
        for (int i = 0; i < 400; i++) begin
            rand_b();
            StallC = ($urandom % 6 == 0); FlushC = ($urandom % 8 == 0);
            ForwardAH = 2'($urandom); ForwardBH = 2'($urandom); WriteResultEH = $urandom;
            #1;
            r = m_redirect(mC);
            checks++;
            if ({PCSrcC, PCTargetC} !== r) begin
                errors++; $display("FAIL rand_redirect[%0d]: got %b/%h want %b/%h", i, PCSrcC, PCTargetC, r[32], r[31:0]);
            end
            step();
            checks++;
            if ({ALUResultD, WriteDataD, PCPlus4D, RdD, RegWriteD, MemWriteD, ResultSrcD, Rs1CH, Rs2CH} !== {mD, mC.rs1, mC.rs2}) begin
                errors++; $display("FAIL rand_regs[%0d]: got %h want %h", i,
                    {ALUResultD, WriteDataD, PCPlus4D, RdD, RegWriteD, MemWriteD, ResultSrcD, Rs1CH, Rs2CH}, {mD, mC.rs1, mC.rs2});
            end
        end
        StallC = 0; FlushC = 0; ForwardAH = 0; ForwardBH = 0;
    endtask

    task automatic test_reset_midstream();
        rand_b(); RegWriteB = 1; RdB = 5'd4;
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        mC = '0; mD = '0;
        checks++;
        if ({ALUResultD, WriteDataD, PCPlus4D, RdD, RegWriteD, MemWriteD, ResultSrcD, Rs1CH, Rs2CH, PCSrcC, PCTargetC} !== 148'd0) begin
            errors++; $display("FAIL reset_mid: got rw=%b rd=%0d alu=%h src=%b", RegWriteD, RdD, ALUResultD, PCSrcC);
        end
        step();
        rst_n = 1'b1;
        clear_b();
        step();
        checks++;
        if ({RegWriteD, RdD, ALUResultD} !== 38'd0) begin
            errors++; $display("FAIL reset_release: got rw=%b rd=%0d alu=%h want 0", RegWriteD, RdD, ALUResultD);
        end
    endtask

    initial begin
        clear_b();
        ForwardAH = 0; ForwardBH = 0; WriteResultEH = 0;
        test_reset();
        test_add();
        test_forward();
        test_branch();
        test_jalr();
        test_stall_flush();
        test_shift_compare();
        test_random();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
